// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator advancing on a pixel-enable strobe.
// Sync/active/sof/eol pass through an optional pixel-tick delay line; xPos/yPos do not.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   DELAY    = 0,
    parameter int   X_W      = 10,
    parameter int   Y_W      = 9,
    parameter int   FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic [X_W-1:0]     xPos,
    output logic [Y_W-1:0]     yPos,
    output logic               Hsync,
    output logic               Vsync,
    output logic               active,
    output logic               sof,
    output logic               eol,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);

    localparam logic [31:0] H_ACT_U  = H_ACTIVE;
    localparam logic [31:0] H_EOL_U  = H_ACTIVE - 1;
    localparam logic [31:0] H_HS0_U  = H_ACTIVE + H_FP;
    localparam logic [31:0] H_HS1_U  = H_ACTIVE + H_FP + H_SYNC;
    localparam logic [31:0] H_LAST_U = H_TOTAL - 1;
    localparam logic [31:0] V_ACT_U  = V_ACTIVE;
    localparam logic [31:0] V_VS0_U  = V_ACTIVE + V_FP;
    localparam logic [31:0] V_VS1_U  = V_ACTIVE + V_FP + V_SYNC;
    localparam logic [31:0] V_LAST_U = V_TOTAL - 1;

    // Delay-line word layout: {hsync, vsync, active, sof, eol}
    localparam logic [4:0] DEASSERT = {~H_POL, ~V_POL, 3'b000};

    logic [HC_W-1:0]    r_h_cnt;
    logic [VC_W-1:0]    r_v_cnt;
    logic [FRAME_W-1:0] r_frame;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [FRAME_W-1:0] r_frame_out;
    logic [DELAY:0][4:0] r_pipe;

    logic [31:0] w_h;
    logic [31:0] w_v;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_hs;
    logic        w_vs;
    logic        w_act;
    logic        w_sof;
    logic        w_eol;
    logic [4:0]  w_dec;

    assign w_h      = 32'(r_h_cnt);
    assign w_v      = 32'(r_v_cnt);
    assign w_h_last = (w_h == H_LAST_U);
    assign w_v_last = (w_v == V_LAST_U);
    assign w_hs     = (w_h >= H_HS0_U) && (w_h < H_HS1_U);
    assign w_vs     = (w_v >= V_VS0_U) && (w_v < V_VS1_U);
    assign w_act    = (w_h < H_ACT_U) && (w_v < V_ACT_U);
    assign w_sof    = (w_h == 32'd0) && (w_v == 32'd0);
    assign w_eol    = (w_h == H_EOL_U) && (w_v < V_ACT_U);
    assign w_dec    = {(w_hs ? H_POL : ~H_POL), (w_vs ? V_POL : ~V_POL), w_act, w_sof, w_eol};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_frame <= '0;
        end else if (pix_en) begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + HC_W'(1);
            if (w_h_last) begin
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + VC_W'(1);
                if (w_v_last) begin
                    r_frame <= r_frame + FRAME_W'(1);
                end
            end
        end
    end

    // Position and frame count are registered from the pre-increment state,
    // so they line up with the undelayed decode stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_frame_out <= '0;
        end else if (pix_en) begin
            r_x         <= w_act ? X_W'(r_h_cnt) : '0;
            r_y         <= w_act ? Y_W'(r_v_cnt) : '0;
            r_frame_out <= r_frame;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe <= {(DELAY + 1){DEASSERT}};
        end else if (pix_en) begin
            r_pipe[0] <= w_dec;
            for (int i = DELAY; i > 0; i--) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign xPos      = r_x;
    assign yPos      = r_y;
    assign frame_cnt = r_frame_out;
    assign {Hsync, Vsync, active, sof, eol} = r_pipe[DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four instances checked every cycle against an
// arithmetic raster model, plus hand-computed literal expectations.
module tb_vga_timing_gen;

    typedef struct packed {
        int   x;
        int   y;
        int   f;
        logic hs;
        logic vs;
        logic act;
        logic sof;
        logic eol;
    } exp_t;

    logic clk;
    logic rst_n;
    logic pix_a;
    logic pix_one;
    logic hold_a;
    logic run;
    int   phase_a;
    int   k_a;
    int   k_1;
    int   n_checks;
    int   n_errs;

    logic [9:0] d_x;  logic [8:0] d_y;  logic [7:0] d_f;
    logic d_hs, d_vs, d_act, d_sof, d_eol;
    logic [9:0] p_x;  logic [8:0] p_y;  logic [7:0] p_f;
    logic p_hs, p_vs, p_act, p_sof, p_eol;
    logic [1:0] s_x;  logic [1:0] s_y;  logic [1:0] s_f;
    logic s_hs, s_vs, s_act, s_sof, s_eol;
    logic [1:0] t_x;  logic [1:0] t_y;  logic [2:0] t_f;
    logic t_hs, t_vs, t_act, t_sof, t_eol;

    vga_timing_gen u_def (
        .clk(clk), .rst(rst_n), .pix_en(pix_a),
        .xPos(d_x), .yPos(d_y), .Hsync(d_hs), .Vsync(d_vs),
        .active(d_act), .sof(d_sof), .eol(d_eol), .frame_cnt(d_f)
    );

    vga_timing_gen #(.DELAY(2)) u_dly (
        .clk(clk), .rst(rst_n), .pix_en(pix_a),
        .xPos(p_x), .yPos(p_y), .Hsync(p_hs), .Vsync(p_vs),
        .active(p_act), .sof(p_sof), .eol(p_eol), .frame_cnt(p_f)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .DELAY(0), .X_W(2), .Y_W(2), .FRAME_W(2)
    ) u_small (
        .clk(clk), .rst(rst_n), .pix_en(pix_one),
        .xPos(s_x), .yPos(s_y), .Hsync(s_hs), .Vsync(s_vs),
        .active(s_act), .sof(s_sof), .eol(s_eol), .frame_cnt(s_f)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b1), .DELAY(4), .X_W(2), .Y_W(2), .FRAME_W(3)
    ) u_sm4 (
        .clk(clk), .rst(rst_n), .pix_en(pix_a),
        .xPos(t_x), .yPos(t_y), .Hsync(t_hs), .Vsync(t_vs),
        .active(t_act), .sof(t_sof), .eol(t_eol), .frame_cnt(t_f)
    );

    // Expected outputs after k pix_en edges since reset release.
    function automatic exp_t model(input int k, input int ha, input int hfp, input int hsy,
                                   input int hbp, input int va, input int vfp, input int vsy,
                                   input int vbp, input logic hp, input logic vp,
                                   input int dly, input int fw);
        int   ht, vt, s, h, v;
        exp_t e;
        ht = ha + hfp + hsy + hbp;
        vt = va + vfp + vsy + vbp;
        e.x = 0; e.y = 0; e.f = 0;
        e.hs = ~hp; e.vs = ~vp; e.act = 1'b0; e.sof = 1'b0; e.eol = 1'b0;
        if (k >= 1) begin
            s = k - 1;
            h = s % ht;
            v = (s / ht) % vt;
            if (h < ha && v < va) begin
                e.x = h;
                e.y = v;
            end
            e.f = (s / (ht * vt)) % (1 << fw);
        end
        if (k - 1 - dly >= 0) begin
            s = k - 1 - dly;
            h = s % ht;
            v = (s / ht) % vt;
            e.hs  = (h >= ha + hfp && h < ha + hfp + hsy) ? hp : ~hp;
            e.vs  = (v >= va + vfp && v < va + vfp + vsy) ? vp : ~vp;
            e.act = (h < ha && v < va);
            e.sof = (h == 0 && v == 0);
            e.eol = (h == ha - 1 && v < va);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input string fld, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s.%s edge=%0d got=%0d expected=%0d", tag, fld, k, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input int k, input exp_t e, input int x, input int y,
                       input int f, input logic hs, input logic vs, input logic act,
                       input logic sof, input logic eol);
        chk(tag, "xPos", k, x, e.x);
        chk(tag, "yPos", k, y, e.y);
        chk(tag, "frame_cnt", k, f, e.f);
        chk(tag, "Hsync", k, int'(hs), int'(e.hs));
        chk(tag, "Vsync", k, int'(vs), int'(e.vs));
        chk(tag, "active", k, int'(act), int'(e.act));
        chk(tag, "sof", k, int'(sof), int'(e.sof));
        chk(tag, "eol", k, int'(eol), int'(e.eol));
    endtask

    task automatic wait_k(input bit sel, input int target);
        int g;
        int cur;
        g = 0;
        do begin
            @(negedge clk);
            g++;
            cur = sel ? k_1 : k_a;
        end while (cur < target && g < 50000);
        chk(sel ? "small" : "def", "edge_reached", target, cur, target);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        pix_a   = 1'b0;
        phase_a = 0;
        forever begin
            @(posedge clk);
            #1;
            phase_a = (phase_a == 3) ? 0 : phase_a + 1;
            pix_a   = (phase_a == 0) && !hold_a;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k_a <= 0;
        else if (pix_a) k_a <= k_a + 1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k_1 <= 0;
        else k_1 <= k_1 + 1;
    end

    always @(negedge clk) begin
        if (run) begin
            cmp("def", k_a, model(k_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0, 8),
                int'(d_x), int'(d_y), int'(d_f), d_hs, d_vs, d_act, d_sof, d_eol);
            cmp("dly", k_a, model(k_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2, 8),
                int'(p_x), int'(p_y), int'(p_f), p_hs, p_vs, p_act, p_sof, p_eol);
            cmp("small", k_1, model(k_1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 0, 2),
                int'(s_x), int'(s_y), int'(s_f), s_hs, s_vs, s_act, s_sof, s_eol);
            cmp("sm4", k_a, model(k_a, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b1, 4, 3),
                int'(t_x), int'(t_y), int'(t_f), t_hs, t_vs, t_act, t_sof, t_eol);
        end
    end

    initial begin
        rst_n    = 1'b0;
        pix_one  = 1'b1;
        hold_a   = 1'b0;
        run      = 1'b0;
        n_checks = 0;
        n_errs   = 0;
        repeat (3) @(posedge clk);
        run = 1'b1;
        @(negedge clk);
        chk("def", "rst_Hsync", 0, int'(d_hs), 1);
        chk("def", "rst_active", 0, int'(d_act), 0);
        chk("small", "rst_Hsync", 0, int'(s_hs), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        fork
            begin
                wait_k(1'b0, 1);
                chk("def", "e1_xPos", 1, int'(d_x), 0);
                chk("def", "e1_yPos", 1, int'(d_y), 0);
                chk("def", "e1_active", 1, int'(d_act), 1);
                chk("def", "e1_sof", 1, int'(d_sof), 1);
                chk("dly", "e1_xPos", 1, int'(p_x), 0);
                chk("dly", "e1_active", 1, int'(p_act), 0);
                wait_k(1'b0, 2);
                chk("dly", "e2_sof", 2, int'(p_sof), 0);
                wait_k(1'b0, 3);
                chk("dly", "e3_active", 3, int'(p_act), 1);
                chk("dly", "e3_sof", 3, int'(p_sof), 1);
                chk("dly", "e3_xPos", 3, int'(p_x), 2);
                wait_k(1'b0, 201);
                chk("def", "e201_xPos", 201, int'(d_x), 200);
                hold_a = 1'b1;
                repeat (100) @(negedge clk);
                chk("def", "hold_xPos", k_a, int'(d_x), 200);
                chk("def", "hold_edges", k_a, k_a, 201);
                hold_a = 1'b0;
                wait_k(1'b0, 202);
                chk("def", "e202_xPos", 202, int'(d_x), 201);
                wait_k(1'b0, 640);
                chk("def", "e640_eol", 640, int'(d_eol), 1);
                chk("def", "e640_xPos", 640, int'(d_x), 639);
                wait_k(1'b0, 656);
                chk("def", "e656_Hsync", 656, int'(d_hs), 1);
                wait_k(1'b0, 657);
                chk("def", "e657_Hsync", 657, int'(d_hs), 0);
                wait_k(1'b0, 659);
                chk("dly", "e659_Hsync", 659, int'(p_hs), 0);
                wait_k(1'b0, 752);
                chk("def", "e752_Hsync", 752, int'(d_hs), 0);
                wait_k(1'b0, 753);
                chk("def", "e753_Hsync", 753, int'(d_hs), 1);
                chk("dly", "e753_Hsync", 753, int'(p_hs), 0);
                wait_k(1'b0, 755);
                chk("dly", "e755_Hsync", 755, int'(p_hs), 1);
                wait_k(1'b0, 801);
                chk("def", "e801_xPos", 801, int'(d_x), 0);
                chk("def", "e801_yPos", 801, int'(d_y), 1);
                wait_k(1'b0, 8301);
                chk("def", "e8301_xPos", 8301, int'(d_x), 300);
                chk("def", "e8301_yPos", 8301, int'(d_y), 10);
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("def", "arst_Hsync", 0, int'(d_hs), 1);
                chk("def", "arst_Vsync", 0, int'(d_vs), 1);
                chk("def", "arst_active", 0, int'(d_act), 0);
                chk("def", "arst_xPos", 0, int'(d_x), 0);
                chk("def", "arst_frame", 0, int'(d_f), 0);
                #1 rst_n = 1'b1;
                wait_k(1'b0, 1);
                chk("def", "rel_xPos", 1, int'(d_x), 0);
                chk("def", "rel_yPos", 1, int'(d_y), 0);
                chk("def", "rel_sof", 1, int'(d_sof), 1);
            end
            begin
                wait_k(1'b1, 5);
                chk("small", "e5_Hsync", 5, int'(s_hs), 0);
                wait_k(1'b1, 6);
                chk("small", "e6_Hsync", 6, int'(s_hs), 1);
                wait_k(1'b1, 7);
                chk("small", "e7_Hsync", 7, int'(s_hs), 1);
                wait_k(1'b1, 8);
                chk("small", "e8_Hsync", 8, int'(s_hs), 0);
                wait_k(1'b1, 32);
                chk("small", "e32_Vsync", 32, int'(s_vs), 0);
                wait_k(1'b1, 33);
                chk("small", "e33_Vsync", 33, int'(s_vs), 1);
                wait_k(1'b1, 41);
                chk("small", "e41_Vsync", 41, int'(s_vs), 0);
                wait_k(1'b1, 48);
                chk("small", "e48_frame", 48, int'(s_f), 0);
                wait_k(1'b1, 49);
                chk("small", "e49_frame", 49, int'(s_f), 1);
                chk("small", "e49_sof", 49, int'(s_sof), 1);
                wait_k(1'b1, 97);
                chk("small", "e97_frame", 97, int'(s_f), 2);
                wait_k(1'b1, 145);
                chk("small", "e145_frame", 145, int'(s_f), 3);
                wait_k(1'b1, 193);
                chk("small", "e193_frame", 193, int'(s_f), 0);
            end
        join

        repeat (40) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
